// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that runs the shared ALU datapath for two requesters. It
// returns each captured result on one response channel tagged with the requester id.
module alu_share_arbiter #(
  parameter int WIDTH   = 4,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH:0]   req0_a,
  input  logic [WIDTH:0]   req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH:0]   req1_a,
  input  logic [WIDTH:0]   req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH:0]   alu_a,
  output logic [WIDTH:0]   alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_load,
  input  logic [WIDTH+1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH+1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic             rsp_sign,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic       ptr;
  logic [3:0] cnt;
  logic       grant0;
  logic       grant1;

  // On contention the pointer decides; a lone valid always wins.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~ptr);
    grant1     = req1_valid & (~req0_valid | ptr);
    req0_ready = rst & (state == IDLE) & grant0;
    req1_ready = rst & (state == IDLE) & grant1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      cnt          <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_load     <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_sign     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      alu_load <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            alu_a    <= req1_ready ? req1_a  : req0_a;
            alu_b    <= req1_ready ? req1_b  : req0_b;
            alu_op   <= req1_ready ? req1_op : req0_op;
            rsp_id   <= req1_ready;
            ptr      <= ~req1_ready;
            alu_load <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= 4'(LATENCY - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            rsp_result   <= alu_result;
            rsp_zero     <= alu_zero;
            rsp_carry    <= alu_carry;
            rsp_overflow <= alu_overflow;
            rsp_sign     <= alu_result[WIDTH+1];
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations plus
// contention, backpressure, reset and latency-variant sequences.
module tb_alu_share_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic r0v, r1v, r0r, r1r;
  logic [W:0] r0a, r0b, r1a, r1b;
  logic [3:0] r0op, r1op;
  logic [W:0] aa, ab;
  logic [3:0] aop;
  logic aload;
  logic [W+1:0] ares;
  logic az, ac, ao;
  logic rv, rrdy, rid, rz, rc, ro, rs, busy;
  logic [W+1:0] rres;

  int total = 0;
  int bad = 0;

  alu_share_arbiter #(.WIDTH(W), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .alu_a(aa), .alu_b(ab), .alu_op(aop), .alu_load(aload),
    .alu_result(ares), .alu_zero(az), .alu_carry(ac), .alu_overflow(ao),
    .rsp_valid(rv), .rsp_ready(rrdy), .rsp_id(rid), .rsp_result(rres),
    .rsp_zero(rz), .rsp_carry(rc), .rsp_overflow(ro), .rsp_sign(rs), .busy(busy)
  );

  // Latency-variant instances driven only through requester 0.
  logic zero1 = 1'b0;
  logic one1 = 1'b1;
  logic av1, av5;
  logic x1_r0r, x1_r1r, x1_load, x1_rv, x1_id, x1_z, x1_c, x1_o, x1_s, x1_busy;
  logic x5_r0r, x5_r1r, x5_load, x5_rv, x5_id, x5_z, x5_c, x5_o, x5_s, x5_busy;
  logic [W:0] x1_a, x1_b, x5_a, x5_b;
  logic [3:0] x1_op, x5_op;
  logic [W+1:0] x1_res, x5_res;

  alu_share_arbiter #(.WIDTH(W), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst),
    .req0_valid(av1), .req0_ready(x1_r0r), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(zero1), .req1_ready(x1_r1r), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .alu_a(x1_a), .alu_b(x1_b), .alu_op(x1_op), .alu_load(x1_load),
    .alu_result(ares), .alu_zero(az), .alu_carry(ac), .alu_overflow(ao),
    .rsp_valid(x1_rv), .rsp_ready(one1), .rsp_id(x1_id), .rsp_result(x1_res),
    .rsp_zero(x1_z), .rsp_carry(x1_c), .rsp_overflow(x1_o), .rsp_sign(x1_s), .busy(x1_busy)
  );

  alu_share_arbiter #(.WIDTH(W), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst),
    .req0_valid(av5), .req0_ready(x5_r0r), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(zero1), .req1_ready(x5_r1r), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .alu_a(x5_a), .alu_b(x5_b), .alu_op(x5_op), .alu_load(x5_load),
    .alu_result(ares), .alu_zero(az), .alu_carry(ac), .alu_overflow(ao),
    .rsp_valid(x5_rv), .rsp_ready(one1), .rsp_id(x5_id), .rsp_result(x5_res),
    .rsp_zero(x5_z), .rsp_carry(x5_c), .rsp_overflow(x5_o), .rsp_sign(x5_s), .busy(x5_busy)
  );

  typedef struct {
    logic       id;
    logic [W:0] a;
    logic [W:0] b;
    logic [3:0] op;
    logic [W+1:0] res;
    logic       z;
    logic       c;
    logic       o;
    logic       sign;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One isolated operation on the LATENCY=2 instance with rsp_ready held high.
  task automatic do_op(input vec_t v);
    int cyc;
    int loads;
    @(negedge clk);
    ares = v.res; az = v.z; ac = v.c; ao = v.o; rrdy = 1'b1;
    if (v.id) begin
      r1v = 1'b1; r1a = v.a; r1b = v.b; r1op = v.op;
    end else begin
      r0v = 1'b1; r0a = v.a; r0b = v.b; r0op = v.op;
    end
    #1;
    chk("grant_ready", v.id ? r1r : r0r, 1);
    chk("other_ready", v.id ? r0r : r1r, 0);
    loads = 0;
    for (cyc = 1; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        r0v = 1'b0; r1v = 1'b0;
        r0a = '1; r0b = '1; r0op = '1; r1a = '1; r1b = '1; r1op = '1;
      end
      if (aload) loads++;
      if (rv) break;
    end
    chk("latency", cyc, 4);
    chk("load_pulses", loads, 1);
    chk("rsp_id", rid, v.id);
    chk("rsp_result", rres, v.res);
    chk("rsp_sign", rs, v.sign);
    chk("rsp_zero", rz, v.z);
    chk("rsp_carry", rc, v.c);
    chk("rsp_overflow", ro, v.o);
    chk("alu_a", aa, v.a);
    chk("alu_b", ab, v.b);
    chk("alu_op", aop, v.op);
    @(negedge clk);
    chk("after_busy", busy, 0);
    chk("after_rsp_valid", rv, 0);
  endtask

  task automatic run_aux(input int sel, input int exp_lat);
    int cyc;
    int loads;
    @(negedge clk);
    r0a = 5'd7; r0b = 5'd3; r0op = 4'h1;
    if (sel == 1) av1 = 1'b1; else av5 = 1'b1;
    #1;
    chk("aux_ready", (sel == 1) ? x1_r0r : x5_r0r, 1);
    loads = 0;
    for (cyc = 1; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin av1 = 1'b0; av5 = 1'b0; end
      if ((sel == 1) ? x1_load : x5_load) loads++;
      if ((sel == 1) ? x1_rv : x5_rv) break;
    end
    chk("aux_latency", cyc, exp_lat);
    chk("aux_load_pulses", loads, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    int n;
    int both;
    int viol;
    int k;

    vecs[0] = '{1'b0, 5'd7,      5'd3,      4'h1, 6'd10,      1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 5'b11101,  5'd0,      4'h2, 6'b111101,  1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 5'd0,      5'd0,      4'h3, 6'd0,       1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 5'd15,     5'd1,      4'h1, 6'b010000,  1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 5'b10000,  5'b10000,  4'hF, 6'b100000,  1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; rrdy = 1'b0; av1 = 1'b0; av5 = 1'b0;
    r0v = 1'b1; r1v = 1'b1;
    r0a = '0; r0b = '0; r0op = '0; r1a = '0; r1b = '0; r1op = '0;
    ares = '0; az = 1'b0; ac = 1'b0; ao = 1'b0;

    // Reset state, with both valids high to show ready stays low.
    repeat (2) @(negedge clk);
    chk("rst_ready0", r0r, 0);
    chk("rst_ready1", r1r, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", aload, 0);
    chk("rst_rsp_valid", rv, 0);
    chk("rst_alu_a", aa, 0);
    chk("rst_rsp_result", rres, 0);
    r0v = 1'b0; r1v = 1'b0;
    rst = 1'b1;

    // Contention: both valid continuously.
    @(negedge clk);
    rrdy = 1'b1; r0v = 1'b1; r1v = 1'b1;
    r0a = 5'd1; r1a = 5'd2;
    n = 0; both = 0;
    for (k = 0; k < 80 && n < 4; k++) begin
      #1;
      if (r0r && r1r) both++;
      if (r0r || r1r) begin
        order[n] = r1r ? 1 : 0;
        n++;
      end
      @(negedge clk);
    end
    r0v = 1'b0; r1v = 1'b0;
    chk("contention_grants", n, 4);
    chk("contention_both_ready", both, 0);
    chk("grant_order0", order[0], 0);
    chk("grant_order1", order[1], 1);
    chk("grant_order2", order[2], 0);
    chk("grant_order3", order[3], 1);
    for (k = 0; k < 20; k++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("contention_drain", busy, 0);

    for (int i = 0; i < 5; i++) do_op(vecs[i]);

    // Backpressure: response held 10 cycles while the ALU result changes.
    @(negedge clk);
    ares = 6'd10; az = 1'b0; ac = 1'b0; ao = 1'b0; rrdy = 1'b0;
    r0v = 1'b1; r0a = 5'd7; r0b = 5'd3; r0op = 4'h1;
    #1;
    chk("bp_ready", r0r, 1);
    for (k = 1; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) r0v = 1'b0;
      if (rv) break;
    end
    chk("bp_latency", k, 4);
    ares = 6'h3F; r1v = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (rv !== 1'b1 || rres !== 6'd10 || r1r !== 1'b0 || busy !== 1'b1) viol++;
    end
    chk("bp_stall_violations", viol, 0);
    chk("bp_result_held", rres, 6'd10);
    r1v = 1'b0; rrdy = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", rv, 0);
    chk("bp_release_busy", busy, 0);

    // Reset in the middle of WAIT; req0 accepted first so the pointer is 1.
    @(negedge clk);
    ares = 6'd21; r0v = 1'b1; r0a = 5'd9; r0b = 5'd4; r0op = 4'h2;
    @(negedge clk);
    r0v = 1'b0;
    @(negedge clk);
    chk("mid_wait_busy", busy, 1);
    rst = 1'b0; r0v = 1'b1; r1v = 1'b1;
    @(negedge clk);
    chk("mr_ready0", r0r, 0);
    chk("mr_ready1", r1r, 0);
    chk("mr_busy", busy, 0);
    chk("mr_rsp_valid", rv, 0);
    chk("mr_alu_a", aa, 0);
    chk("mr_alu_b", ab, 0);
    chk("mr_alu_op", aop, 0);
    chk("mr_rsp_result", rres, 0);
    rst = 1'b1;
    #1;
    chk("mr_ptr_ready0", r0r, 1);
    chk("mr_ptr_ready1", r1r, 0);
    for (k = 1; k < 30; k++) begin
      @(negedge clk);
      if (k == 1) begin r0v = 1'b0; r1v = 1'b0; end
      if (rv) break;
    end
    chk("mr_next_latency", k, 4);
    chk("mr_next_id", rid, 0);
    chk("mr_next_result", rres, 6'd21);
    @(negedge clk);

    run_aux(1, 3);
    run_aux(5, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Sequences the shared ALU datapath (operand registers -> ALU -> result register) on behalf of two independent requesters.
- Requesters present operands and an op code over a valid/ready handshake. The block arbitrates round-robin, drives ALU operands and op, pulses the load strobe, and waits a fixed settle latency. It then captures the result and flags and returns them on one response channel tagged with the requester id.
- Sits between the front-end sources (switch panel, test sequencer) and the ALU/BCD/display path. It replaces direct switch-driven control of the load strobe.

Parameters:
- WIDTH, 4, operand MSB index; operands are WIDTH+1 bits and the result is WIDTH+2 bits.
- LATENCY, 2, number of WAIT cycles between the load pulse and result capture; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH+1  requester 0 operand A (signed).
- req0_b  in  WIDTH+1  requester 0 operand B (signed).
- req0_op  in  4  requester 0 ALU op code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same directions, widths and meanings for requester 1.
- alu_a  out  WIDTH+1  registered operand A to the datapath.
- alu_b  out  WIDTH+1  registered operand B to the datapath.
- alu_op  out  4  registered op code to the ALU.
- alu_load  out  1  one-cycle load strobe to the operand/result registers.
- alu_result  in  WIDTH+2  ALU result.
- alu_zero  in  1  ALU zero flag.
- alu_carry  in  1  ALU carry-out flag.
- alu_overflow  in  1  ALU overflow flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH+2  captured result.
- rsp_zero, rsp_carry, rsp_overflow  out  1 each  captured flags.
- rsp_sign  out  1  captured result MSB.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0 at a rising edge):
  - State goes to IDLE, the priority pointer goes to 0, and the wait counter goes to 0.
  - All outputs are 0: alu_a, alu_b, alu_op, alu_load, rsp_*, busy. req*_ready is 0 while rst=0.
  - Reset overrides every other event, including reset mid-operation. An in-flight operation is discarded with no response.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational: it is high in IDLE for the granted requester only, and never high for both in the same cycle.
  - Grant rule: if only one valid is high, that requester is granted. If both are high, the requester equal to the priority pointer is granted.
  - On acceptance (valid & ready) at edge t:
    - alu_a, alu_b and alu_op latch the granted request's operands and op.
    - rsp_id latches the granted index.
    - The pointer becomes the other index.
    - The state moves to ISSUE.
  - If no valid is high, the block stays in IDLE and all registers hold.
- ISSUE: alu_load=1 for exactly this one cycle. The counter loads LATENCY-1 and the state moves to WAIT.
- WAIT:
  - Lasts exactly LATENCY cycles; the counter decrements each cycle.
  - In the cycle the counter is 0, alu_result and the flags are sampled into rsp_* at the closing edge, and the state moves to RESP.
- RESP:
  - rsp_valid=1 and all rsp_* are held stable until rsp_valid & rsp_ready, then the state moves to IDLE.
  - Responses are never dropped; backpressure can last indefinitely.
- Timing: with acceptance in cycle 0, ISSUE is cycle 1, WAIT is cycles 2..LATENCY+1, and rsp_valid first rises in cycle LATENCY+2.
  - The earliest next acceptance is the cycle after the response handshake.
  - Minimum period is LATENCY+3 cycles per operation.
- Operand stability: alu_a, alu_b and alu_op change only on acceptance and are held through WAIT and RESP.
- The requester's own inputs may change after acceptance without effect.
- Starvation bound: a requester holding valid waits for at most one operation of the other requester.
- Op codes are passed through unchecked; result width and sign interpretation belong to the ALU.
- rsp_sign always equals rsp_result[WIDTH+1].

Test Plan:
- Reset then single request: req0 with a=5'sd7, b=5'sd3, op=4'h1; bench ALU model drives alu_result=6'd10, flags 0. Required: req0_ready in cycle 0; alu_load in cycle 1 only; rsp_valid in cycle 4 with rsp_id=0, rsp_result=6'd10, rsp_sign=0.
- Simultaneous contention: req0 and req1 valid continuously for 4 operations with rsp_ready=1. Required: grant order 0,1,0,1 and never both ready in the same cycle.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP with alu_result changed to 6'h3F during the stall. Required: rsp_valid stays high, rsp_result stays 6'd10, no new ready, busy=1; handshake then return to IDLE.
- Negative/flags: alu_result=6'b111101 (-3), alu_zero=0, alu_carry=1, alu_overflow=1. Required: rsp_sign=1, rsp_carry=1, rsp_overflow=1, rsp_result=6'b111101.
- Reset mid-WAIT: assert rst=0 for one cycle during WAIT. Required: next cycle state IDLE, busy=0, alu_* and rsp_*=0, no rsp_valid; next request is granted to req0 (pointer reset).
- LATENCY=1 and LATENCY=5 builds: measure accept-to-rsp_valid. Required: 3 and 7 cycles respectively; alu_load is a single-cycle pulse in both.
